// File: rtl/branch_cond_unit_pkg.sv
// rtl/branch_cond_unit_pkg.sv - shared ALU flag, condition-code and opcode definitions
package branch_cond_unit_pkg;

  // Branch condition codes evaluated against the effective flags.
  typedef enum logic [3:0] {
    COND_EQ  = 4'd0,
    COND_NE  = 4'd1,
    COND_GT  = 4'd2,
    COND_LE  = 4'd3,
    COND_LT  = 4'd4,
    COND_GE  = 4'd5,
    COND_CS  = 4'd6,
    COND_CC  = 4'd7,
    COND_MI  = 4'd8,
    COND_PL  = 4'd9,
    COND_VS  = 4'd10,
    COND_VC  = 4'd11,
    COND_AL  = 4'd12,
    COND_R13 = 4'd13,
    COND_R14 = 4'd14,
    COND_R15 = 4'd15
  } cond_e;

  // Flag bundle in status-register bit order {gt,n,z,c,v}.
  typedef struct packed {
    logic gt;
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // ALUControl opcodes of the producing ALU.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_XOR = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_MUL = 3'd6;

  // Resolution slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// rtl/branch_cond_unit_cond_eval.sv - combinational condition-code evaluator
module branch_cond_unit_cond_eval
  import branch_cond_unit_pkg::*;
(
  input  alu_flags_t i_flags,
  input  cond_e      i_cond,
  output logic       o_taken
);

  // Map the condition code onto the flag bundle; reserved codes never take.
  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = i_flags.z;
      COND_NE: o_taken = ~i_flags.z;
      COND_GT: o_taken = i_flags.gt;
      COND_LE: o_taken = ~i_flags.gt;
      COND_LT: o_taken = i_flags.n ^ i_flags.v;
      COND_GE: o_taken = ~(i_flags.n ^ i_flags.v);
      COND_CS: o_taken = i_flags.c;
      COND_CC: o_taken = ~i_flags.c;
      COND_MI: o_taken = i_flags.n;
      COND_PL: o_taken = ~i_flags.n;
      COND_VS: o_taken = i_flags.v;
      COND_VC: o_taken = ~i_flags.v;
      COND_AL: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - status register, branch resolution slot and mispredict counter
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int N     = 24,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flag_we,
  input  logic             i_flag_gt,
  input  logic             i_flag_n,
  input  logic             i_flag_z,
  input  logic             i_flag_c,
  input  logic             i_flag_v,
  input  logic             i_br_valid,
  output logic             o_br_ready,
  input  logic [3:0]       i_br_cond,
  input  logic [N-1:0]     i_br_target,
  input  logic             i_br_pred,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_taken,
  output logic [N-1:0]     o_res_target,
  output logic             o_res_mispred,
  input  logic             i_flush,
  output logic [4:0]       o_sr,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  alu_flags_t       r_sr;
  slot_state_e      r_state;
  logic             r_res_taken;
  logic [N-1:0]     r_res_target;
  logic             r_res_mispred;
  logic [CNT_W-1:0] r_cnt;

  alu_flags_t w_live;
  alu_flags_t w_eff;
  logic       w_taken;
  logic       w_accept;
  logic       w_deliver;

  assign w_live = '{gt: i_flag_gt, n: i_flag_n, z: i_flag_z, c: i_flag_c, v: i_flag_v};

  // Same-cycle forwarding: a branch issued alongside a flag write sees the new flags.
  assign w_eff = i_flag_we ? w_live : r_sr;

  branch_cond_unit_cond_eval u_cond_eval (
    .i_flags (w_eff),
    .i_cond  (cond_e'(i_br_cond)),
    .o_taken (w_taken)
  );

  assign o_res_valid = (r_state == SLOT_FULL);
  assign o_br_ready  = ~o_res_valid | i_res_ready;
  assign w_accept    = i_br_valid & o_br_ready & ~i_flush;
  assign w_deliver   = o_res_valid & i_res_ready & ~i_flush;

  // Status register tracks every flag-writing ALU op, regardless of branch traffic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_flag_we) begin
      r_sr <= w_live;
    end
  end

  // Single-entry resolution slot: load on accept, drain on ready, empty on flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= SLOT_EMPTY;
      r_res_taken   <= 1'b0;
      r_res_target  <= '0;
      r_res_mispred <= 1'b0;
    end else if (i_flush) begin
      r_state <= SLOT_EMPTY;
    end else if (w_accept) begin
      r_state       <= SLOT_FULL;
      r_res_taken   <= w_taken;
      r_res_target  <= i_br_target;
      r_res_mispred <= w_taken ^ i_br_pred;
    end else if (i_res_ready) begin
      r_state <= SLOT_EMPTY;
    end
  end

  // Count mispredicts as they are handed to fetch; stick at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_deliver && r_res_mispred && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_res_taken   = r_res_taken;
  assign o_res_target  = r_res_target;
  assign o_res_mispred = r_res_mispred;
  assign o_sr          = r_sr;
  assign o_mispred_cnt = r_cnt;

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb/tb_branch_cond_unit.sv - directed self-checking bench for branch_cond_unit
module tb_branch_cond_unit;

  localparam int N     = 24;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flag_we, fgt, fn, fz, fc, fv;
  logic             br_valid, br_pred, res_ready, flush;
  logic [3:0]       br_cond;
  logic [N-1:0]     br_target;
  logic             br_ready, res_valid, res_taken, res_mispred;
  logic [N-1:0]     res_target;
  logic [4:0]       sr;
  logic [CNT_W-1:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_cond_unit #(.N(N), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_flag_we     (flag_we),
    .i_flag_gt     (fgt),
    .i_flag_n      (fn),
    .i_flag_z      (fz),
    .i_flag_c      (fc),
    .i_flag_v      (fv),
    .i_br_valid    (br_valid),
    .o_br_ready    (br_ready),
    .i_br_cond     (br_cond),
    .i_br_target   (br_target),
    .i_br_pred     (br_pred),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_taken   (res_taken),
    .o_res_target  (res_target),
    .o_res_mispred (res_mispred),
    .i_flush       (flush),
    .o_sr          (sr),
    .o_mispred_cnt (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Flags as a 5-bit vector {gt,n,z,c,v}.
  function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
    bit gt = f[4], n = f[3], z = f[2], cy = f[1], v = f[0];
    bit r;
    case (c)
      0: r = z;          1: r = !z;
      2: r = gt;         3: r = !gt;
      4: r = n != v;     5: r = n == v;
      6: r = cy;         7: r = !cy;
      8: r = n;          9: r = !n;
      10: r = v;         11: r = !v;
      12: r = 1;
      default: r = 0;
    endcase
    return r;
  endfunction

  logic [4:0]   m_sr;
  logic         m_valid, m_taken, m_mis;
  logic [N-1:0] m_tgt;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sr <= 0; m_valid <= 0; m_taken <= 0; m_tgt <= 0; m_mis <= 0; m_cnt <= 0;
    end else begin
      if (m_valid && res_ready && m_mis && !flush && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      if (flag_we) m_sr <= {fgt, fn, fz, fc, fv};
      if (flush) m_valid <= 0;
      else if (br_valid && (!m_valid || res_ready)) begin
        m_valid <= 1;
        m_taken <= cond_ok(br_cond, flag_we ? {fgt, fn, fz, fc, fv} : m_sr);
        m_tgt   <= br_target;
        m_mis   <= cond_ok(br_cond, flag_we ? {fgt, fn, fz, fc, fv} : m_sr) != br_pred;
      end else if (res_ready) m_valid <= 0;
    end
  end

  // Compare process: outputs against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmp_res_valid", 32'(res_valid), 32'(m_valid));
      chk("cmp_br_ready", 32'(br_ready), 32'(!m_valid || res_ready));
      chk("cmp_sr", 32'(sr), 32'(m_sr));
      chk("cmp_cnt", 32'(cnt), 32'(m_cnt));
      if (m_valid) begin
        chk("cmp_taken", 32'(res_taken), 32'(m_taken));
        chk("cmp_target", 32'(res_target), 32'(m_tgt));
        chk("cmp_mispred", 32'(res_mispred), 32'(m_mis));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] f, input logic bv, input logic [3:0] c,
                       input logic [N-1:0] t, input logic p, input logic rr, input logic fl);
    flag_we = we; {fgt, fn, fz, fc, fv} = f;
    br_valid = bv; br_cond = c; br_target = t; br_pred = p;
    res_ready = rr; flush = fl;
  endtask

  task automatic idle(input logic rr);
    drive(0, 5'b0, 0, 4'd0, '0, 0, rr, 0);
  endtask

  int saved_cnt;

  initial begin
    rst_n = 1'b0;
    idle(0);
    tick; tick;
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_sr", 32'(sr), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_taken", 32'(res_taken), 0);
    chk("rst_target", 32'(res_target), 0);
    rst_n = 1'b1;
    tick;

    // Forwarding: flag write and EQ branch in the same cycle.
    drive(1, 5'b00100, 1, 4'd0, 24'h00ABCD, 0, 0, 0);
    tick;
    idle(0);
    chk("fwd_valid", 32'(res_valid), 1);
    chk("fwd_taken", 32'(res_taken), 1);
    chk("fwd_target", 32'(res_target), 32'h00ABCD);
    chk("fwd_mispred", 32'(res_mispred), 1);
    chk("fwd_sr", 32'(sr), 32'b00100);
    idle(1);
    tick;
    chk("fwd_drained", 32'(res_valid), 0);
    chk("fwd_cnt", 32'(cnt), 1);

    // Signed LT against the stored and forwarded flags, plus a reserved code.
    drive(1, 5'b01001, 0, 4'd0, '0, 0, 1, 0);
    tick;
    chk("lt_sr", 32'(sr), 32'b01001);
    drive(0, 5'b0, 1, 4'd4, 24'h10, 0, 1, 0);
    tick;
    chk("lt_nv11", 32'(res_taken), 0);
    drive(1, 5'b01000, 1, 4'd4, 24'h20, 0, 1, 0);
    tick;
    chk("lt_nv10", 32'(res_taken), 1);
    drive(0, 5'b0, 1, 4'd14, 24'h30, 1, 1, 0);
    tick;
    chk("rsv14_taken", 32'(res_taken), 0);
    chk("rsv14_mispred", 32'(res_mispred), 1);

    // Sweep every condition code against random flags.
    for (int i = 0; i < 48; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), 1, 4'(i % 16), 24'($urandom),
            1'($urandom_range(0, 1)), 1, 0);
      tick;
    end
    idle(1);
    tick;

    // Backpressure: slot holds while fetch stalls, then reloads back-to-back.
    drive(0, 5'b0, 1, 4'd12, 24'h111, 1, 0, 0);
    tick;
    drive(0, 5'b0, 1, 4'd12, 24'h222, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready_low", 32'(br_ready), 0);
      tick;
      chk("bp_hold_target", 32'(res_target), 32'h111);
      chk("bp_hold_valid", 32'(res_valid), 1);
    end
    res_ready = 1;
    #1 chk("bp_ready_high", 32'(br_ready), 1);
    tick;
    chk("bp_reload", 32'(res_target), 32'h222);
    br_target = 24'h333;
    tick;
    chk("bp_b2b_1", 32'(res_target), 32'h333);
    br_target = 24'h444;
    tick;
    chk("bp_b2b_2", 32'(res_target), 32'h444);
    idle(1);
    tick;
    chk("bp_empty", 32'(res_valid), 0);

    // Flush kills both the pending and the incoming resolution.
    drive(0, 5'b0, 1, 4'd12, 24'h555, 0, 0, 0);
    tick;
    saved_cnt = m_cnt;
    drive(0, 5'b0, 1, 4'd12, 24'h666, 0, 1, 1);
    tick;
    chk("flush_valid", 32'(res_valid), 0);
    chk("flush_cnt", 32'(cnt), 32'(saved_cnt));
    idle(1);
    tick;
    chk("flush_stay_empty", 32'(res_valid), 0);

    // Asynchronous reset in the middle of a held transfer.
    drive(0, 5'b10111, 1, 4'd12, 24'h777, 0, 0, 0);
    tick;
    drive(1, 5'b10111, 1, 4'd12, 24'h888, 0, 0, 0);
    #3 rst_n = 1'b0;
    #2;
    chk("arst_valid", 32'(res_valid), 0);
    chk("arst_sr", 32'(sr), 0);
    chk("arst_cnt", 32'(cnt), 0);
    idle(1);
    tick;
    rst_n = 1'b1;
    tick;
    chk("arst_no_emit", 32'(res_valid), 0);

    // 17 delivered mispredicts saturate the 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      drive(0, 5'b0, 1, 4'd12, 24'(i), 0, 1, 0);
      tick;
    end
    idle(1);
    tick;
    chk("sat_cnt", 32'(cnt), 32'hF);
    drive(0, 5'b0, 1, 4'd12, 24'h999, 0, 1, 0);
    tick;
    idle(1);
    tick;
    chk("sat_no_wrap", 32'(cnt), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
